// File: rtl/arith_engine.sv
// Handshaked arithmetic engine: ADD, iterative shift-add MUL/MAC, accumulator CLR.
// One transaction at a time; result and ovf hold until the next completion.
module arith_engine #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_MAC, OP_CLR} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] prod_step;
  logic [ACC_W:0]   mac_sum;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // The final partial-product step is folded into the completion edge so the
  // result lands exactly WIDTH edges after accept.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mac_sum   = {1'b0, acc_q} + {1'b0, prod_step};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d = op_e'(op);
          case (op_e'(op))
            OP_ADD: begin
              result_d = ACC_W'(a) + ACC_W'(b);
              ovf_d    = 1'b0;
              state_d  = DONE;
            end
            OP_CLR: begin
              acc_d    = '0;
              result_d = '0;
              ovf_d    = 1'b0;
              state_d  = DONE;
            end
            default: begin
              mcand_d  = ACC_W'(a);
              mplier_d = b;
              prod_d   = '0;
              cnt_d    = CW'(WIDTH);
              state_d  = BUSY;
            end
          endcase
        end
      end
      BUSY: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (op_q == OP_MAC) begin
            acc_d    = mac_sum[ACC_W-1:0];
            result_d = mac_sum[ACC_W-1:0];
            ovf_d    = mac_sum[ACC_W];
          end else begin
            result_d = prod_step;
            ovf_d    = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arith_engine.sv
// Self-checking bench for arith_engine (WIDTH=4, ACC_W=12) against an
// arithmetic reference model of the accumulator and op semantics.
module tb_arith_engine;

  localparam int W = 4;
  localparam int AW = 12;
  localparam logic [1:0] ADD = 2'd0, MUL = 2'd1, MAC = 2'd2, CLR = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] result;
  logic          ovf;

  int total = 0;
  int bad = 0;
  int m_acc = 0;

  arith_engine #(.WIDTH(W), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on a persistent accumulator.
  function automatic void ref_step(input logic [1:0] o, input int x, input int y,
                                   output int er, output logic eo, output int ew);
    int s;
    case (o)
      ADD: begin er = x + y; eo = 1'b0; ew = 0; end
      MUL: begin er = x * y; eo = 1'b0; ew = W; end
      MAC: begin
        s = m_acc + x * y;
        er = s % (1 << AW);
        eo = (s >= (1 << AW));
        m_acc = er;
        ew = W;
      end
      default: begin m_acc = 0; er = 0; eo = 1'b0; ew = 0; end
    endcase
  endfunction

  // Drives one transaction from a negedge, captures the output, completes the
  // handshake with out_ready high and returns just after the next negedge.
  task automatic drive_txn(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [AW-1:0] r, output logic v, output int waits,
                           output logic rdy_seen, output logic ok);
    int n;
    ok = 1'b1;
    rdy_seen = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waits = 0;
    while (!out_valid && waits < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      waits++;
    end
    if (in_ready) rdy_seen = 1'b1;
    if (waits >= 100) ok = 1'b0;
    r = result;
    v = ovf;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; op = ADD; a = '0; b = '0; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== '0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got ov=%b res=%0d ovf=%b rdy=%b want 0 0 0 1", out_valid, result, ovf, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add;
    logic [AW-1:0] r; logic v, rs, ok; int w, er, ew; logic eo;
    drive_txn(ADD, 4'd15, 4'd15, r, v, w, rs, ok);
    ref_step(ADD, 15, 15, er, eo, ew);
    total++;
    if (!ok || r !== AW'(er) || v !== eo || w != ew) begin
      bad++; $display("FAIL add_max: got res=%0d ovf=%b lat=%0d ok=%b want %0d %b %0d", r, v, w, ok, er, eo, ew);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL add_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_mul;
    logic [AW-1:0] r; logic v, rs, ok; int w, er, ew; logic eo;
    drive_txn(MUL, 4'd15, 4'd13, r, v, w, rs, ok);
    ref_step(MUL, 15, 13, er, eo, ew);
    total++;
    if (!ok || r !== AW'(er) || v !== eo || w != ew || rs !== 1'b0) begin
      bad++; $display("FAIL mul_15x13: got res=%0d ovf=%b lat=%0d rdy=%b want %0d %b %0d 0", r, v, w, rs, er, eo, ew);
    end
    drive_txn(MAC, 4'd1, 4'd1, r, v, w, rs, ok);
    ref_step(MAC, 1, 1, er, eo, ew);
    total++;
    if (!ok || r !== AW'(er) || v !== eo) begin
      bad++; $display("FAIL mul_acc_untouched: got res=%0d ovf=%b want %0d %b", r, v, er, eo);
    end
  endtask

  task automatic test_mac_ovf;
    logic [AW-1:0] r; logic v, rs, ok; int w, er, ew; logic eo; int errs;
    drive_txn(CLR, 4'd3, 4'd3, r, v, w, rs, ok);
    ref_step(CLR, 3, 3, er, eo, ew);
    errs = 0;
    for (int i = 1; i <= 19; i++) begin
      drive_txn(MAC, 4'd15, 4'd15, r, v, w, rs, ok);
      ref_step(MAC, 15, 15, er, eo, ew);
      total++;
      if (!ok || r !== AW'(er) || v !== eo || w != ew) begin
        bad++; $display("FAIL mac_seq[%0d]: got res=%0d ovf=%b lat=%0d want %0d %b %0d", i, r, v, w, er, eo, ew);
      end
    end
    total++;
    if (r !== 12'd179 || v !== 1'b1) begin bad++; $display("FAIL mac_wrap: got res=%0d ovf=%b want 179 1", r, v); end
    drive_txn(MAC, 4'd1, 4'd0, r, v, w, rs, ok);
    ref_step(MAC, 1, 0, er, eo, ew);
    total++;
    if (!ok || r !== AW'(er) || v !== eo || w != ew) begin
      bad++; $display("FAIL mac_zero_operand: got res=%0d ovf=%b lat=%0d want %0d %b %0d", r, v, w, er, eo, ew);
    end
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] r; logic v, rs, ok; int w, er, ew, n; logic eo;
    out_ready = 1'b0;
    in_valid = 1'b1; op = MUL; a = 4'd9; b = 4'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    ref_step(MUL, 9, 9, er, eo, ew);
    total++;
    if (n >= 50 || result !== AW'(er)) begin bad++; $display("FAIL bp_mul: got res=%0d waits=%0d want %0d", result, n, er); end
    in_valid = 1'b1; op = ADD; a = 4'd1; b = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || result !== AW'(er) || ovf !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: got ov=%b res=%0d ovf=%b rdy=%b want 1 %0d 0 0", i, out_valid, result, ovf, in_ready, er);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_txn(ADD, 4'd1, 4'd1, r, v, w, rs, ok);
    ref_step(ADD, 1, 1, er, eo, ew);
    total++;
    if (!ok || r !== AW'(er) || v !== eo || w != ew) begin
      bad++; $display("FAIL bp_add_after: got res=%0d ovf=%b lat=%0d want %0d %b %0d", r, v, w, er, eo, ew);
    end
  endtask

  task automatic test_reset_midop;
    logic [AW-1:0] r; logic v, rs, ok; int w, er, ew; logic eo; logic seen;
    drive_txn(CLR, 4'd0, 4'd0, r, v, w, rs, ok);
    ref_step(CLR, 0, 0, er, eo, ew);
    drive_txn(MAC, 4'd10, 4'd10, r, v, w, rs, ok);
    ref_step(MAC, 10, 10, er, eo, ew);
    total++;
    if (r !== AW'(er)) begin bad++; $display("FAIL rmid_setup: got res=%0d want %0d", r, er); end
    in_valid = 1'b1; op = MAC; a = 4'd7; b = 4'd7;
    @(posedge clk);            // E0
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;                // sampled at E0+2
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      bad++; $display("FAIL rmid_after: got rdy=%b ov=%b res=%0d want 1 0 0", in_ready, out_valid, result);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 2; i++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rmid_no_result: got out_valid seen=%b want 0", seen); end
    drive_txn(MAC, 4'd1, 4'd1, r, v, w, rs, ok);
    ref_step(MAC, 1, 1, er, eo, ew);
    total++;
    if (!ok || r !== AW'(er) || v !== eo) begin
      bad++; $display("FAIL rmid_acc_cleared: got res=%0d ovf=%b want %0d %b", r, v, er, eo);
    end
  endtask

  task automatic test_clr;
    logic [AW-1:0] r; logic v, rs, ok; int w, er, ew; logic eo;
    drive_txn(CLR, 4'd0, 4'd0, r, v, w, rs, ok);
    ref_step(CLR, 0, 0, er, eo, ew);
    for (int i = 0; i < 5; i++) begin
      drive_txn(MAC, 4'd10, 4'd10, r, v, w, rs, ok);
      ref_step(MAC, 10, 10, er, eo, ew);
    end
    total++;
    if (r !== AW'(er) || er != 500) begin bad++; $display("FAIL clr_setup: got res=%0d want 500", r); end
    drive_txn(CLR, 4'd9, 4'd9, r, v, w, rs, ok);
    ref_step(CLR, 9, 9, er, eo, ew);
    total++;
    if (!ok || r !== '0 || v !== 1'b0 || w != 0) begin
      bad++; $display("FAIL clr_result: got res=%0d ovf=%b lat=%0d want 0 0 0", r, v, w);
    end
    drive_txn(MAC, 4'd2, 4'd3, r, v, w, rs, ok);
    ref_step(MAC, 2, 3, er, eo, ew);
    total++;
    if (!ok || r !== AW'(er) || v !== eo) begin bad++; $display("FAIL clr_then_mac: got res=%0d ovf=%b want %0d %b", r, v, er, eo); end
  endtask

  task automatic test_random;
    logic [AW-1:0] r; logic v, rs, ok; int w, er, ew; logic eo;
    logic [1:0] o; logic [W-1:0] x, y;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      x = W'($urandom_range(0, 15));
      y = W'($urandom_range(0, 15));
      drive_txn(o, x, y, r, v, w, rs, ok);
      ref_step(o, int'(x), int'(y), er, eo, ew);
      total++;
      if (!ok || r !== AW'(er) || v !== eo || w != ew || rs !== 1'b0) begin
        bad++; $display("FAIL rand[%0d] op=%0d a=%0d b=%0d: got res=%0d ovf=%b lat=%0d rdy=%b want %0d %b %0d 0",
                        i, o, x, y, r, v, w, rs, er, eo, ew);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_mac_ovf;
    test_backpressure;
    test_reset_midop;
    test_clr;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
